// File: rtl/dpot_pkg.sv
// Shared types and helpers for the Pmod DPOT ramp controller.
// Holds the FSM state set and the bounded-step code arithmetic.
package dpot_pkg;

  localparam int DPOT_CODE_W = 8;
  localparam logic [DPOT_CODE_W-1:0] DPOT_CODE_MIN = 8'h00;
  localparam logic [DPOT_CODE_W-1:0] DPOT_CODE_MAX = 8'hFF;

  typedef logic [DPOT_CODE_W-1:0] code_t;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    REQ,
    BUSY,
    DWELL
  } state_t;

  function automatic code_t next_code(
    input code_t cur,
    input code_t tgt,
    input code_t step
  );
    logic [8:0] diff;
    logic [8:0] inc;
    logic [8:0] sum;
    logic [8:0] room;
    code_t      res;
    diff = '0;
    inc  = '0;
    sum  = '0;
    room = '0;
    res  = cur;
    unique case (1'b1)
      (tgt > cur): begin
        diff = {1'b0, tgt} - {1'b0, cur};
        inc  = ({1'b0, step} < diff) ? {1'b0, step} : diff;
        sum  = {1'b0, cur} + inc;
        res  = (sum > {1'b0, DPOT_CODE_MAX}) ? DPOT_CODE_MAX : sum[7:0];
      end
      (tgt < cur): begin
        diff = {1'b0, cur} - {1'b0, tgt};
        inc  = ({1'b0, step} < diff) ? {1'b0, step} : diff;
        room = {1'b0, cur} - {1'b0, DPOT_CODE_MIN};
        sum  = {1'b0, cur} - inc;
        res  = (room < inc) ? DPOT_CODE_MIN : sum[7:0];
      end
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dpot_ready_sync.sv
// Two-flop synchronizer for a ready flag from a divided clock domain.
// Resets to 1 so the far side reads as idle out of reset.
module dpot_ready_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dpot_ramp_ctrl.sv
// Slews the DPOT wiper to a target in bounded steps with a dwell per step.
// Optional handshake timeout: define DPOT_RAMP_TIMEOUT_EN.
module dpot_ramp_ctrl
  import dpot_pkg::*;
#(
  parameter int          DWELL_W     = 16,
  parameter logic [7:0]  INIT_CODE   = 8'h00,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         target,
  input  logic [7:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  output logic [7:0]         dpot_value,
  output logic               dpot_update,
  input  logic               dpot_ready,
  output logic [7:0]         wiper,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  state_t             state;
  state_t             state_n;
  code_t              tgt_l;
  code_t              step_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [DWELL_W-1:0] cnt;
  logic               rdy_s;
  logic               to_exp;
  logic               at_tgt;

  dpot_ready_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dpot_ready),
    .q   (rdy_s)
  );

  assign at_tgt = (wiper == tgt_l);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // A start seen in CALC re-evaluates next cycle against the fresh target.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = CALC;
      end
      CALC: begin
        if (start)       state_n = CALC;
        else if (at_tgt) state_n = IDLE;
        else             state_n = REQ;
      end
      REQ: begin
        if (!rdy_s)      state_n = BUSY;
        else if (to_exp) state_n = IDLE;
      end
      BUSY: begin
        if (rdy_s)       state_n = (dwell_l == '0) ? CALC : DWELL;
        else if (to_exp) state_n = IDLE;
      end
      DWELL: begin
        if (cnt == '0) state_n = CALC;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dpot_update = 1'b0;
    busy        = 1'b0;
    dpot_update = (state == REQ);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_l      <= INIT_CODE;
      step_l     <= 8'h01;
      dwell_l    <= '0;
      cnt        <= '0;
      dpot_value <= INIT_CODE;
      wiper      <= INIT_CODE;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        tgt_l   <= target;
        step_l  <= (step == '0) ? 8'h01 : step;
        dwell_l <= dwell;
      end
      if (state == CALC && !start) begin
        if (at_tgt) done       <= 1'b1;
        else        dpot_value <= next_code(wiper, tgt_l, step_l);
      end
      if (state == BUSY && rdy_s) begin
        wiper <= dpot_value;
        cnt   <= dwell_l - 1'b1;
      end
      if (state == DWELL && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

`ifdef DPOT_RAMP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;
  logic            to_flag;

  assign waiting = (state == REQ) || (state == BUSY);
  assign to_exp  = waiting && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign timeout = to_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (!waiting || state_n != state) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;
      if (to_exp && state_n == IDLE) to_flag <= 1'b1;
    end
  end
`else
  logic unused_to;

  assign unused_to = TIMEOUT_CYC[0];
  assign to_exp    = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
